// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   Write/read control for the index FIFO storage array. Converts compare-stage
//   matches (eq & wr_req) into storage writes and FPU read requests into storage
//   reads, tracks occupancy, and reports full/empty, read-data-valid and sticky
//   overflow/underflow flags. The storage array itself lives outside this block.
//
// Ports
//   clk      in   clock, all state updates on posedge
//   rst_n    in   asynchronous active-low reset
//   eq       in   compare stage: indices equal this cycle
//   wr_req   in   external write enable; push request = eq & wr_req
//   rd_req   in   FPU read request
//   flush    in   synchronous clear of pointers, count and error flags
//   w_en     out  storage write enable (combinational)
//   waddr    out  storage write address (write pointer, zero-extended)
//   raddr    out  storage read address (read pointer, zero-extended)
//   full     out  occupancy == ENTRIES (registered)
//   empty    out  occupancy == 0 (registered)
//   count    out  current occupancy
//   rd_valid out  storage output holds the entry popped on the previous edge
//   ovf      out  sticky: push requested while full and not popping
//   udf      out  sticky: pop requested while empty
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int ENTRIES = 4,
  parameter int AW      = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          eq,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          flush,
  output logic          w_en,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          rd_valid,
  output logic          ovf,
  output logic          udf
);

  // Pointer width; depth need not be a power of two, so wrap is explicit.
  localparam int            PW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [PW-1:0] LAST = PW'(ENTRIES - 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_req;
  logic          pop_ok;
  logic          push_ok;
  logic          ovf_set;
  logic          udf_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign push_req = eq & wr_req;
  assign pop_ok   = rd_req & ~empty;
  // A full FIFO still takes a push when the same edge frees the head slot.
  assign push_ok  = push_req & (~full | pop_ok);
  assign ovf_set  = push_req & full & ~pop_ok;
  assign udf_set  = rd_req & empty;

  // Gated by rst_n so the storage is never written while the pointers are held.
  assign w_en  = push_ok & ~flush & rst_n;
  assign waddr = AW'(wr_ptr);
  assign raddr = AW'(rd_ptr);

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok) count_nxt = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_nxt;
      full     <= (count_nxt == CW'(ENTRIES));
      empty    <= (count_nxt == '0);
      rd_valid <= pop_ok;
      ovf      <= ovf | ovf_set;
      udf      <= udf | udf_set;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//   Two instances (depth 4 and depth 3) share one stimulus stream. A list-based
//   reference model and a simple storage model track each instance; a negedge
//   process compares every output every cycle, and directed sections pin the
//   model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic eq, wr_req, rd_req, flush;
  int   din;

  logic       w_en_o  [2];
  logic [3:0] waddr_o [2];
  logic [3:0] raddr_o [2];
  logic       full_o  [2];
  logic       empty_o [2];
  logic       rv_o    [2];
  logic       ovf_o   [2];
  logic       udf_o   [2];
  logic [2:0] cnt4;
  logic [1:0] cnt3;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a plain list, addresses as modular counters.
  int depth [2] = '{4, 3};
  int m_q   [2][16];
  int m_n   [2];
  int m_wp  [2];
  int m_rp  [2];
  bit m_ovf [2];
  bit m_udf [2];
  bit m_rv  [2];
  int m_rdata [2];

  // Storage array model driven by the DUT's own w_en/waddr/raddr.
  int mem  [2][16];
  int dout [2];

  bit pr, po, pu;

  fifo_ctrl #(.ENTRIES(4), .AW(4), .CW(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .eq(eq), .wr_req(wr_req), .rd_req(rd_req),
    .flush(flush), .w_en(w_en_o[0]), .waddr(waddr_o[0]), .raddr(raddr_o[0]),
    .full(full_o[0]), .empty(empty_o[0]), .count(cnt4), .rd_valid(rv_o[0]),
    .ovf(ovf_o[0]), .udf(udf_o[0])
  );

  fifo_ctrl #(.ENTRIES(3), .AW(4), .CW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .eq(eq), .wr_req(wr_req), .rd_req(rd_req),
    .flush(flush), .w_en(w_en_o[1]), .waddr(waddr_o[1]), .raddr(raddr_o[1]),
    .full(full_o[1]), .empty(empty_o[1]), .count(cnt3), .rd_valid(rv_o[1]),
    .ovf(ovf_o[1]), .udf(udf_o[1])
  );

  initial forever #5 clk = ~clk;

  function automatic int dut_cnt(input int k);
    return (k == 0) ? int'(cnt4) : int'(cnt3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_n[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
    m_ovf[k] = 1'b0; m_udf[k] = 1'b0; m_rv[k] = 1'b0;
  endtask

  // Storage captures dataIn and registers fifo[raddr] at each edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      dout[k] = mem[k][raddr_o[k]];
      if (w_en_o[k]) mem[k][waddr_o[k]] = din;
    end
  end

  // Compare process: outputs against the model, then advance the model with
  // the inputs that will be sampled at the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check($sformatf("rst_w_en[%0d]", k),  w_en_o[k],  0);
        check($sformatf("rst_count[%0d]", k), dut_cnt(k), 0);
        check($sformatf("rst_empty[%0d]", k), empty_o[k], 1);
        check($sformatf("rst_full[%0d]", k),  full_o[k],  0);
        check($sformatf("rst_rv[%0d]", k),    rv_o[k],    0);
        check($sformatf("rst_ovf[%0d]", k),   ovf_o[k],   0);
        check($sformatf("rst_udf[%0d]", k),   udf_o[k],   0);
        check($sformatf("rst_waddr[%0d]", k), waddr_o[k], 0);
        check($sformatf("rst_raddr[%0d]", k), raddr_o[k], 0);
        model_reset(k);
      end else begin
        pr = eq && wr_req;
        po = rd_req && (m_n[k] > 0);
        pu = pr && ((m_n[k] < depth[k]) || po);
        check($sformatf("w_en[%0d]", k),  w_en_o[k],  pu && !flush);
        check($sformatf("waddr[%0d]", k), waddr_o[k], m_wp[k]);
        check($sformatf("raddr[%0d]", k), raddr_o[k], m_rp[k]);
        check($sformatf("count[%0d]", k), dut_cnt(k), m_n[k]);
        check($sformatf("full[%0d]", k),  full_o[k],  m_n[k] == depth[k]);
        check($sformatf("empty[%0d]", k), empty_o[k], m_n[k] == 0);
        check($sformatf("rv[%0d]", k),    rv_o[k],    m_rv[k]);
        check($sformatf("ovf[%0d]", k),   ovf_o[k],   m_ovf[k]);
        check($sformatf("udf[%0d]", k),   udf_o[k],   m_udf[k]);
        if (m_rv[k]) check($sformatf("rdata[%0d]", k), dout[k], m_rdata[k]);

        if (flush) begin
          model_reset(k);
        end else begin
          if (pr && m_n[k] == depth[k] && !po) m_ovf[k] = 1'b1;
          if (rd_req && m_n[k] == 0)           m_udf[k] = 1'b1;
          if (po) begin
            m_rdata[k] = m_q[k][0];
            for (int j = 0; j < 15; j++) m_q[k][j] = m_q[k][j+1];
            m_n[k]--;
            m_rp[k] = (m_rp[k] + 1) % depth[k];
          end
          if (pu) begin
            m_q[k][m_n[k]] = din;
            m_n[k]++;
            m_wp[k] = (m_wp[k] + 1) % depth[k];
          end
          m_rv[k] = po;
        end
      end
    end
  end

  task automatic tick(input bit e, input bit w, input bit r, input bit f, input int d);
    @(posedge clk);
    #1;
    eq = e; wr_req = w; rd_req = r; flush = f; din = d;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    eq = 1'b0; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; din = 0;
    #23 rst_n = 1'b1;

    // Four pushes fill the depth-4 instance; a fifth overflows.
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 0, 100 + i);
      peek();
      check("push_waddr", waddr_o[0], i);
      check("push_w_en", w_en_o[0], 1);
    end
    tick(1, 1, 0, 0, 104);
    peek();
    check("fill_full", full_o[0], 1);
    check("fill_count", cnt4, 4);
    check("ovf_push_w_en", w_en_o[0], 0);
    tick(0, 0, 0, 0, 0);
    peek();
    check("ovf_flag", ovf_o[0], 1);

    // Drain: read addresses in order, data valid one cycle later, push order.
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0, 0);
      peek();
      check("pop_raddr", raddr_o[0], i);
      if (i > 0) begin
        check("pop_rv", rv_o[0], 1);
        check("pop_data", dout[0], 100 + i - 1);
      end
    end
    tick(0, 0, 0, 0, 0);
    peek();
    check("last_rv", rv_o[0], 1);
    check("last_data", dout[0], 103);
    check("drain_empty", empty_o[0], 1);
    check("drain_count", cnt4, 0);

    // Pop while empty with a push: pop rejected, push taken.
    tick(1, 1, 1, 0, 120);
    peek();
    check("udf_push_w_en", w_en_o[0], 1);
    tick(0, 0, 0, 0, 0);
    peek();
    check("udf_flag", udf_o[0], 1);
    check("udf_rv", rv_o[0], 0);
    check("udf_count", cnt4, 1);
    check("udf_empty", empty_o[0], 0);

    // Flush with count=2 and ovf set.
    tick(1, 1, 0, 0, 121);
    tick(0, 0, 0, 1, 0);
    peek();
    check("pre_flush_count", cnt4, 2);
    check("pre_flush_ovf", ovf_o[0], 1);
    tick(0, 0, 0, 0, 0);
    peek();
    check("flush_count", cnt4, 0);
    check("flush_empty", empty_o[0], 1);
    check("flush_ovf", ovf_o[0], 0);
    check("flush_udf", udf_o[0], 0);

    // Push+pop while full: write and read hit slot 0, old head comes back.
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 130 + i);
    tick(1, 1, 1, 0, 134);
    peek();
    check("pp_w_en", w_en_o[0], 1);
    check("pp_waddr", waddr_o[0], 0);
    check("pp_raddr", raddr_o[0], 0);
    tick(0, 0, 0, 0, 0);
    peek();
    check("pp_count", cnt4, 4);
    check("pp_rv", rv_o[0], 1);
    check("pp_data", dout[0], 130);

    // Fill/drain the depth-3 instance ten times so its pointers wrap 2->0.
    tick(0, 0, 0, 1, 0);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 1000 + r * 10 + i);
      for (int i = 0; i < 3; i++) begin
        tick(0, 0, 1, 0, 0);
        peek();
        if (i == 0) check("wrap_full3", full_o[1], 1);
      end
      tick(0, 0, 0, 0, 0);
      peek();
      check("wrap_data3", dout[1], 1000 + r * 10 + 2);
      check("wrap_empty3", empty_o[1], 1);
    end

    // Random traffic with an asynchronous reset pulse in the middle.
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0, int'($urandom));
      if (n == 1500) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          check("async_count", dut_cnt(k), 0);
          check("async_empty", empty_o[k], 1);
          check("async_full", full_o[k], 0);
          check("async_w_en", w_en_o[k], 0);
          check("async_rv", rv_o[k], 0);
          check("async_flags", {ovf_o[k], udf_o[k]}, 0);
          check("async_addr", {waddr_o[k], raddr_o[k]}, 0);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end

    tick(0, 0, 0, 0, 0);
    peek();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
